// File: rtl/shift_mult_unit.sv
// Multi-cycle MUL/SLL/SRL/SRA/ROR unit fed by the register file; one bit-step per clock.
// BUSYWAIT stalls the CPU while working, DONE strobes one cycle with RESULT valid.
module shift_mult_unit #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [2:0]            i_opsel,
   input  logic [DATA_WIDTH-1:0] i_data1,
   input  logic [DATA_WIDTH-1:0] i_data2,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_busywait,
   output logic                  o_done
);

   localparam logic [2:0] OP_MUL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_result;
   logic [2:0]            r_op;
   logic [3:0]            r_cnt;

   logic                  w_accept;
   logic                  w_step;
   logic                  w_last;
   logic [3:0]            w_cnt_load;
   logic [DATA_WIDTH-1:0] w_a_shift;
   logic [DATA_WIDTH-1:0] w_acc_add;
   logic [DATA_WIDTH-1:0] w_a_nxt;
   logic [DATA_WIDTH-1:0] w_acc_nxt;

   assign w_accept   = i_start && (r_state == S_IDLE || r_state == S_FIN);
   assign w_step     = (r_state == S_RUN) && (r_cnt != 4'd0);
   // A zero count still spends one RUN cycle, so "last" covers both 1 and 0.
   assign w_last     = (r_state == S_RUN) && (r_cnt <= 4'd1);
   assign o_busywait = !i_reset && (w_accept || r_state == S_RUN);
   assign o_done     = (r_state == S_FIN);
   assign o_result   = r_result;

   always_comb begin
      w_cnt_load = 4'd0;
      case (i_opsel)
         OP_MUL:                 w_cnt_load = 4'd8;
         OP_SLL, OP_SRL, OP_SRA: w_cnt_load = (|i_data2[DATA_WIDTH-1:3]) ? 4'd8 : {1'b0, i_data2[2:0]};
         OP_ROR:                 w_cnt_load = {1'b0, i_data2[2:0]};
         default:                w_cnt_load = 4'd0;
      endcase
   end

   always_comb begin
      w_a_shift = r_a;
      case (r_op)
         OP_MUL, OP_SLL: w_a_shift = {r_a[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:         w_a_shift = {1'b0, r_a[DATA_WIDTH-1:1]};
         OP_SRA:         w_a_shift = {r_a[DATA_WIDTH-1], r_a[DATA_WIDTH-1:1]};
         OP_ROR:         w_a_shift = {r_a[0], r_a[DATA_WIDTH-1:1]};
         default:        w_a_shift = r_a;
      endcase
      w_acc_add = (r_op == OP_MUL && r_b[0]) ? (r_acc + r_a) : r_acc;
      w_a_nxt   = w_step ? w_a_shift : r_a;
      w_acc_nxt = w_step ? w_acc_add : r_acc;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_FIN;
         S_FIN:   w_next_state = i_start ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_op     <= 3'b000;
         r_cnt    <= 4'd0;
         r_result <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_a   <= i_data1;
            r_b   <= i_data2;
            r_op  <= i_opsel;
            r_acc <= '0;
            r_cnt <= w_cnt_load;
         end else if (w_step) begin
            r_a   <= w_a_shift;
            r_b   <= r_b >> 1;
            r_acc <= w_acc_add;
            r_cnt <= r_cnt - 4'd1;
         end
         // RESULT only moves on the FIN-entry edge, using this cycle's final step.
         if (w_last) begin
            r_result <= (r_op == OP_MUL) ? w_acc_nxt : w_a_nxt;
         end
      end
   end

endmodule

// File: tb/tb_shift_mult_unit.sv
// Self-checking bench for shift_mult_unit: scoreboard of expected results, latency,
// BUSYWAIT/DONE handshake, back-to-back issue and reset abort.
module tb_shift_mult_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] opsel;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [7:0] result;
   logic       busywait;
   logic       done;

   int         cmp_cnt = 0;
   int         err_cnt = 0;
   int         cyc;
   logic [7:0] exp_q[$];

   // op, A, B, expected RESULT, expected cycles from START cycle to DONE
   localparam int NT = 11;
   logic [2:0] t_op  [NT] = '{3'b011, 3'b010, 3'b001, 3'b100, 3'b011, 3'b001,
                              3'b000, 3'b000, 3'b110, 3'b100, 3'b010};
   logic [7:0] t_a   [NT] = '{8'h90, 8'h90, 8'h5A, 8'h81, 8'h90, 8'h81,
                              8'h20, 8'hFF, 8'h3C, 8'h81, 8'h90};
   logic [7:0] t_b   [NT] = '{8'h02, 8'h09, 8'h00, 8'h09, 8'h09, 8'h03,
                              8'h10, 8'hFF, 8'h77, 8'h08, 8'h03};
   logic [7:0] t_exp [NT] = '{8'hE4, 8'h00, 8'h5A, 8'hC0, 8'hFF, 8'h08,
                              8'h00, 8'h01, 8'h3C, 8'h81, 8'h12};
   int         t_lat [NT] = '{3, 9, 2, 2, 9, 4, 9, 9, 2, 2, 4};

   always #5 clk = ~clk;

   shift_mult_unit #(.DATA_WIDTH(8)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_opsel    (opsel),
      .i_data1    (data1),
      .i_data2    (data2),
      .o_result   (result),
      .o_busywait (busywait),
      .o_done     (done)
   );

   // Called at a negedge: raises START for one cycle, leaves the bench one edge past accept.
   task automatic start_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic busy0);
      opsel = op;
      data1 = a;
      data2 = b;
      start = 1'b1;
      #1 busy0 = busywait;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
   endtask

   // Bounded wait for DONE; reports latency (-1 on timeout), stall gaps and early RESULT moves.
   task automatic wait_done(output int lat, output bit busy_bad, output bit res_moved);
      logic [7:0] r0;
      r0        = result;
      busy_bad  = 1'b0;
      res_moved = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busywait !== 1'b1) busy_bad = 1'b1;
         if (result !== r0) res_moved = 1'b1;
         @(negedge clk);
         cyc++;
      end
      lat = (done === 1'b1) ? cyc : -1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if (result !== 8'h00) begin err_cnt++; $display("FAIL reset_result: got %h want 00", result); end
      cmp_cnt++;
      if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
      cmp_cnt++;
      if (busywait !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busywait); end
   endtask

   task automatic test_mul;
      logic       b0;
      int         lat;
      bit         bb, rm;
      logic [7:0] e;
      exp_q.push_back(8'h8F);
      start_op(3'b000, 8'h0D, 8'h0B, b0);
      cmp_cnt++;
      if (b0 !== 1'b1) begin err_cnt++; $display("FAIL mul_busy_at_start: got %b want 1", b0); end
      wait_done(lat, bb, rm);
      cmp_cnt++;
      if (lat !== 9) begin err_cnt++; $display("FAIL mul_latency: got %0d want 9", lat); end
      cmp_cnt++;
      if (bb !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_run: got gap=%b want 0", bb); end
      cmp_cnt++;
      if (rm !== 1'b0) begin err_cnt++; $display("FAIL mul_result_stable: got moved=%b want 0", rm); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      cmp_cnt++;
      if (result !== e) begin err_cnt++; $display("FAIL mul_result: got %h want %h", result, e); end
      cmp_cnt++;
      if (busywait !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_fin: got %b want 0", busywait); end
      @(negedge clk);
      cmp_cnt++;
      if (done !== 1'b0) begin err_cnt++; $display("FAIL mul_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_table;
      logic       b0;
      int         lat;
      bit         bb, rm;
      logic [7:0] e;
      for (int i = 0; i < NT; i++) begin
         exp_q.push_back(t_exp[i]);
         start_op(t_op[i], t_a[i], t_b[i], b0);
         wait_done(lat, bb, rm);
         cmp_cnt++;
         if (lat !== t_lat[i]) begin
            err_cnt++; $display("FAIL op%0d_latency: got %0d want %0d", i, lat, t_lat[i]);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         cmp_cnt++;
         if (result !== e) begin err_cnt++; $display("FAIL op%0d_result: got %h want %h", i, result, e); end
         cmp_cnt++;
         if (bb !== 1'b0 || rm !== 1'b0) begin
            err_cnt++; $display("FAIL op%0d_run: got busy_gap=%b result_moved=%b want 0 0", i, bb, rm);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      logic       b0;
      int         lat;
      bit         bb, rm;
      logic [7:0] e;
      int         dones;
      dones = 0;
      exp_q.push_back(8'hC0);
      start_op(3'b100, 8'h81, 8'h01, b0);
      wait_done(lat, bb, rm);
      if (done === 1'b1) dones++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      cmp_cnt++;
      if (result !== e) begin err_cnt++; $display("FAIL b2b_first_result: got %h want %h", result, e); end
      exp_q.push_back(8'h30);
      start_op(3'b001, 8'h03, 8'h04, b0);
      cmp_cnt++;
      if (b0 !== 1'b1) begin err_cnt++; $display("FAIL b2b_busy_in_fin: got %b want 1", b0); end
      cmp_cnt++;
      if (busywait !== 1'b1 || done !== 1'b0) begin
         err_cnt++; $display("FAIL b2b_no_bubble: got busy=%b done=%b want 1 0", busywait, done);
      end
      wait_done(lat, bb, rm);
      if (done === 1'b1) dones++;
      cmp_cnt++;
      if (lat !== 5) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 5", lat); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      cmp_cnt++;
      if (result !== e) begin err_cnt++; $display("FAIL b2b_second_result: got %h want %h", result, e); end
      cmp_cnt++;
      if (dones !== 2) begin err_cnt++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic b0;
      bit   spur;
      start_op(3'b000, 8'h0D, 8'h0B, b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      opsel = 3'b001;
      data1 = 8'h55;
      data2 = 8'h01;
      #1;
      cmp_cnt++;
      if (busywait !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_forced: got %b want 0", busywait); end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      #1;
      cmp_cnt++;
      if (result !== 8'h00) begin err_cnt++; $display("FAIL rst_mid_result: got %h want 00", result); end
      cmp_cnt++;
      if (busywait !== 1'b0 || done !== 1'b0) begin
         err_cnt++; $display("FAIL rst_mid_idle: got busy=%b done=%b want 0 0", busywait, done);
      end
      spur = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done !== 1'b0 || busywait !== 1'b0) spur = 1'b1;
      end
      cmp_cnt++;
      if (spur !== 1'b0) begin err_cnt++; $display("FAIL rst_no_activity: got activity=%b want 0", spur); end
      cmp_cnt++;
      if (result !== 8'h00) begin err_cnt++; $display("FAIL rst_result_hold: got %h want 00", result); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      opsel = 3'b000;
      data1 = 8'h00;
      data2 = 8'h00;
      test_reset;
      test_mul;
      test_table;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
